// File: rtl/vector_list_reader.sv
// vector_list_reader: walks the vector display-list RAM from address 0 on a
// frame request. Each draw entry becomes one segment command for the line
// drawer. The walk stops at the end marker, or at LIST_MAX if no marker is
// found, and then a one-cycle frame_done pulse is issued.
module vector_list_reader #(
  parameter int OUT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18,
  parameter int LIST_MAX  = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 draw_frame,
  output logic                 frame_done,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic [OUT_WIDTH-1:0] x0,
  output logic [OUT_WIDTH-1:0] y0,
  output logic [OUT_WIDTH-1:0] x1,
  output logic [OUT_WIDTH-1:0] y1,
  output logic                 line_start,
  input  logic                 line_done,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    DECODE,
    LINE_WAIT,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [OUT_WIDTH-1:0] px, py, px_n, py_n;
  logic [OUT_WIDTH-1:0] x0_n, y0_n, x1_n, y1_n;
  logic [ADR_WIDTH-1:0] adr_n;
  logic                 line_start_n, frame_done_n, busy_n;
  logic                 draw_frame_q;

  // Entry fields: {x, y, line, pos}
  logic [OUT_WIDTH-1:0] ent_x, ent_y;
  logic [1:0]           ent_kind;
  logic                 at_max;

  assign ent_x    = dataREAD[DATAWIDTH-1 -: OUT_WIDTH];
  assign ent_y    = dataREAD[DATAWIDTH-OUT_WIDTH-1 -: OUT_WIDTH];
  assign ent_kind = dataREAD[1:0];
  assign at_max   = (adrREAD == ADR_WIDTH'(LIST_MAX));

  // Next-state and next-value logic; every output is registered from these.
  always_comb begin
    state_n      = state;
    adr_n        = adrREAD;
    px_n         = px;
    py_n         = py;
    x0_n         = x0;
    y0_n         = y0;
    x1_n         = x1;
    y1_n         = y1;
    line_start_n = 1'b0;
    case (state)
      IDLE: begin
        adr_n = '0;
        px_n  = '0;
        py_n  = '0;
        if (draw_frame && !draw_frame_q) state_n = WAIT_DATA;
      end
      WAIT_DATA: state_n = DECODE;
      DECODE: begin
        case (ent_kind)
          2'b11: state_n = FINISH;
          2'b10: begin
            // Segment starts at the current pen; pen then moves to the end.
            x0_n         = px;
            y0_n         = py;
            x1_n         = ent_x;
            y1_n         = ent_y;
            px_n         = ent_x;
            py_n         = ent_y;
            line_start_n = 1'b1;
            state_n      = LINE_WAIT;
          end
          default: begin
            if (ent_kind == 2'b01) begin
              px_n = ent_x;
              py_n = ent_y;
            end
            if (at_max) begin
              state_n = FINISH;
            end else begin
              adr_n   = adrREAD + ADR_WIDTH'(1);
              state_n = WAIT_DATA;
            end
          end
        endcase
      end
      LINE_WAIT: begin
        if (line_done) begin
          if (at_max) begin
            state_n = FINISH;
          end else begin
            adr_n   = adrREAD + ADR_WIDTH'(1);
            state_n = WAIT_DATA;
          end
        end
      end
      FINISH: begin
        adr_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    frame_done_n = (state_n == FINISH);
    busy_n       = (state_n != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      adrREAD      <= '0;
      px           <= '0;
      py           <= '0;
      x0           <= '0;
      y0           <= '0;
      x1           <= '0;
      y1           <= '0;
      line_start   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      draw_frame_q <= 1'b0;
    end else begin
      state        <= state_n;
      adrREAD      <= adr_n;
      px           <= px_n;
      py           <= py_n;
      x0           <= x0_n;
      y0           <= y0_n;
      x1           <= x1_n;
      y1           <= y1_n;
      line_start   <= line_start_n;
      frame_done   <= frame_done_n;
      busy         <= busy_n;
      draw_frame_q <= draw_frame;
    end
  end

endmodule

// File: tb/tb_vector_list_reader.sv
// Directed bench for vector_list_reader: RAM and line-drawer models with
// hand-computed segment lists and cycle positions.
module tb_vector_list_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_frame;
  logic        frame_done;
  logic [15:0] adrREAD;
  logic [17:0] dataREAD;
  logic [7:0]  x0, y0, x1, y1;
  logic        line_start;
  logic        line_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [17:0] mem [0:65535];

  // Run-result bookkeeping filled by run_list
  logic [31:0] segs [0:7];
  int          ls_cyc [0:7];
  int          seg_n, fd_n, fd_cyc, max_adr;
  bit          overlap, timed_out;

  always #5 clk = ~clk;

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk) dataREAD <= mem[adrREAD];

  vector_list_reader #(
    .OUT_WIDTH(8),
    .ADR_WIDTH(16),
    .DATAWIDTH(18),
    .LIST_MAX (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .draw_frame(draw_frame),
    .frame_done(frame_done),
    .adrREAD   (adrREAD),
    .dataREAD  (dataREAD),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .line_start(line_start),
    .line_done (line_done),
    .busy      (busy)
  );

  function automatic logic [17:0] ent(input int x, input int y, input bit l, input bit p);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb, yb, l, p};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 18'h0;
  endtask

  task automatic load_polyline();
    clear_mem();
    mem[0] = ent(5, 5, 0, 1);
    mem[1] = ent(100, 5, 1, 0);
    mem[2] = ent(100, 200, 1, 0);
    mem[3] = ent(0, 0, 1, 1);
  endtask

  // Low for one cycle then high: the posedge after this returns samples the edge.
  task automatic start_frame();
    @(negedge clk);
    draw_frame = 1'b0;
    @(negedge clk);
    draw_frame = 1'b1;
  endtask

  // Behaves as the drawer (line_done 'delay' cycles after line_start) and
  // records segments until the frame completes or the budget expires.
  // Cycle 0 is the first sample after the start edge is taken.
  task automatic run_list(input int delay, input bit spur, input int budget);
    int cnt;
    bit pending;
    seg_n = 0; fd_n = 0; fd_cyc = -1; max_adr = 0;
    overlap = 0; timed_out = 1; pending = 0; cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      line_done = 1'b0;
      if (int'(adrREAD) > max_adr) max_adr = int'(adrREAD);
      if (spur && c == 0) line_done = 1'b1;
      if (line_start) begin
        if (pending) overlap = 1;
        if (seg_n < 8) begin
          segs[seg_n]   = {x0, y0, x1, y1};
          ls_cyc[seg_n] = c;
        end
        seg_n++;
        pending = 1;
        cnt = delay;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          line_done = 1'b1;
          pending = 0;
        end
      end
      if (frame_done) begin
        fd_n++;
        if (fd_cyc < 0) fd_cyc = c;
      end
      if (fd_n > 0 && !busy) begin
        timed_out = 0;
        break;
      end
    end
    line_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, frame_done, line_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/frame_done/line_start=%b expected 000", {busy, frame_done, line_start});
    end
    checks++;
    if (adrREAD !== 16'h0) begin
      errors++;
      $display("FAIL reset_adr: got %0d expected 0", adrREAD);
    end
    checks++;
    if ({x0, y0, x1, y1} !== 32'h0) begin
      errors++;
      $display("FAIL reset_coords: got %h expected 00000000", {x0, y0, x1, y1});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_segment();
    clear_mem();
    mem[0] = ent(0, 0, 0, 0);
    mem[1] = ent(10, 20, 0, 1);
    mem[2] = ent(50, 60, 1, 0);
    mem[3] = ent(0, 0, 1, 1);
    start_frame();
    run_list(5, 0, 300);
    checks++;
    if (timed_out || seg_n != 1 || fd_n != 1) begin
      errors++;
      $display("FAIL single_counts: timeout=%0d segs=%0d done=%0d expected 0/1/1", timed_out, seg_n, fd_n);
    end
    checks++;
    if (segs[0] !== {8'd10, 8'd20, 8'd50, 8'd60}) begin
      errors++;
      $display("FAIL single_seg: got %h expected %h", segs[0], {8'd10, 8'd20, 8'd50, 8'd60});
    end
    checks++;
    if (ls_cyc[0] != 6 || fd_cyc != 14) begin
      errors++;
      $display("FAIL single_timing: line_start@%0d frame_done@%0d expected 6/14", ls_cyc[0], fd_cyc);
    end
    checks++;
    if (adrREAD !== 16'h0) begin
      errors++;
      $display("FAIL single_adr_end: got %0d expected 0", adrREAD);
    end
  endtask

  task automatic test_polyline();
    load_polyline();
    start_frame();
    run_list(3, 0, 300);
    checks++;
    if (timed_out || seg_n != 2 || fd_n != 1 || overlap) begin
      errors++;
      $display("FAIL poly_counts: timeout=%0d segs=%0d done=%0d overlap=%0d expected 0/2/1/0", timed_out, seg_n, fd_n, overlap);
    end
    checks++;
    if (segs[0] !== {8'd5, 8'd5, 8'd100, 8'd5}) begin
      errors++;
      $display("FAIL poly_seg0: got %h expected %h", segs[0], {8'd5, 8'd5, 8'd100, 8'd5});
    end
    checks++;
    if (segs[1] !== {8'd100, 8'd5, 8'd100, 8'd200}) begin
      errors++;
      $display("FAIL poly_seg1: got %h expected %h", segs[1], {8'd100, 8'd5, 8'd100, 8'd200});
    end
    checks++;
    if (ls_cyc[0] != 4 || ls_cyc[1] != 10 || fd_cyc != 16) begin
      errors++;
      $display("FAIL poly_timing: ls0@%0d ls1@%0d done@%0d expected 4/10/16", ls_cyc[0], ls_cyc[1], fd_cyc);
    end
  endtask

  task automatic test_no_retrigger();
    bit woke;
    load_polyline();
    start_frame();
    run_list(2, 0, 300);
    woke = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || frame_done || line_start) woke = 1;
    end
    checks++;
    if (woke) begin
      errors++;
      $display("FAIL no_retrigger: busy seen=%0d expected 0 with draw_frame held high", woke);
    end
    start_frame();
    run_list(2, 0, 300);
    checks++;
    if (timed_out || seg_n != 2 || segs[0] !== {8'd5, 8'd5, 8'd100, 8'd5}) begin
      errors++;
      $display("FAIL rescan: timeout=%0d segs=%0d seg0=%h expected 0/2/0505_6405", timed_out, seg_n, segs[0]);
    end
  endtask

  task automatic test_list_max();
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = ent(i, i + 1, 0, 1);
    mem[8] = ent(9, 9, 1, 0);
    start_frame();
    run_list(2, 0, 300);
    checks++;
    if (timed_out || fd_n != 1 || seg_n != 0) begin
      errors++;
      $display("FAIL max_counts: timeout=%0d done=%0d segs=%0d expected 0/1/0", timed_out, fd_n, seg_n);
    end
    checks++;
    if (max_adr != 7) begin
      errors++;
      $display("FAIL max_adr: highest address %0d expected 7", max_adr);
    end
    checks++;
    if (fd_cyc != 16) begin
      errors++;
      $display("FAIL max_timing: frame_done@%0d expected 16", fd_cyc);
    end
  endtask

  task automatic test_reset_mid_list();
    bit seen, stray;
    load_polyline();
    start_frame();
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (line_start) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_reach: line_start seen=%0d expected 1", seen);
    end
    @(negedge clk);
    rst = 1'b1;
    draw_frame = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, frame_done, line_start, adrREAD, x0, y0, x1, y1} !== 51'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%0d fd=%0d ls=%0d adr=%0d coords=%h expected all 0",
               busy, frame_done, line_start, adrREAD, {x0, y0, x1, y1});
    end
    rst = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done || busy) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_mid_after: frame_done/busy seen=%0d expected 0", stray);
    end
  endtask

  task automatic test_spurious_done();
    bit moved;
    clear_mem();
    mem[0] = ent(0, 0, 0, 0);
    mem[1] = ent(10, 20, 0, 1);
    mem[2] = ent(50, 60, 1, 0);
    mem[3] = ent(0, 0, 1, 1);
    moved = 0;
    repeat (3) begin
      @(negedge clk);
      line_done = 1'b1;
      @(negedge clk);
      line_done = 1'b0;
      if (busy || adrREAD !== 16'h0) moved = 1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL spur_idle: state/address changed=%0d expected 0", moved);
    end
    start_frame();
    run_list(5, 1, 300);
    checks++;
    if (timed_out || seg_n != 1 || segs[0] !== {8'd10, 8'd20, 8'd50, 8'd60} || ls_cyc[0] != 6 || fd_cyc != 14) begin
      errors++;
      $display("FAIL spur_wait: timeout=%0d segs=%0d seg0=%h ls@%0d done@%0d expected 0/1/0a14323c/6/14",
               timed_out, seg_n, segs[0], ls_cyc[0], fd_cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    draw_frame = 1'b0;
    line_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 18'h0;
    test_reset();
    test_single_segment();
    test_polyline();
    test_no_retrigger();
    test_list_max();
    test_reset_mid_list();
    test_spurious_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
